bf_scheduler: RTL and testbench
===============================

BF_SCHEDULER -- requirements
Module: bf_scheduler

Interface
REQ-001 Parameter: NODES, 32, vertex count; one relaxation pass per edge sweep, NODES-1 passes per solve.
REQ-002 Parameter: PW, 5, address width of row, column and vertex indices (ports are [PW-1:0]).
REQ-003 Parameter: WW, 32, edge-weight width (ports are [WW-1:0]).
REQ-004 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-005 Port: reset_n  in  1  synchronous, active-low reset.
REQ-006 Port: start  in  1  one-cycle request to run a full solve.
REQ-007 Port: upd_valid / upd_ready  in / out  1 / 1  market-data edge-update handshake.
REQ-008 Port: upd_row, upd_col  in  PW each  edge coordinates; upd_weight  in  WW  new signed log-rate weight.
REQ-009 Port: adj_we  out  1; adj_wrow, adj_wcol  out  PW; adj_wdata  out  WW  adjacency-matrix write port.
REQ-010 Port: relax_reset  out  1; relax_done  in  1; relax_changed  in  1  relaxation-engine control; relax_changed is valid while relax_done=1.
REQ-011 Port: cycle_reset  out  1; cycle_done  in  1  cycle-detector control.
REQ-012 Port: busy  out  1; pass_cnt  out  PW; done  out  1  status: solve active, passes completed, one-cycle completion pulse.

Function
REQ-013 States: IDLE, RELAX_RST, RELAX_RUN, CYC_RST, CYC_RUN, FINISH; encoding is registered and one-hot-safe.
REQ-014 upd_ready=1 only in IDLE; adjmat is write-locked in every other state.
REQ-015 Update accepted when upd_valid & upd_ready; adj_we=1 with captured row/col/weight on the next cycle, exactly one cycle.
REQ-016 start and an accepted update in the same cycle: the update is written, start is latched in start_pend, and the solve begins on the following cycle.
REQ-017 IDLE -> RELAX_RST on start or start_pend, provided no update is accepted that cycle; pass_cnt cleared to 0, start_pend cleared.
REQ-018 RELAX_RST: relax_reset=1 for exactly one cycle, then RELAX_RUN.
REQ-019 RELAX_RUN: relax_done is ignored on the first RELAX_RUN cycle (stale done); afterwards relax_done=1 increments pass_cnt.
REQ-020 After increment, pass_cnt==NODES-1 -> CYC_RST; otherwise -> RELAX_RST.
REQ-021 CYC_RST: cycle_reset=1 for exactly one cycle, then CYC_RUN; cycle_done ignored on the first CYC_RUN cycle, then cycle_done=1 -> FINISH.
REQ-022 FINISH: done=1 for one cycle, then IDLE; pass_cnt holds its final value until the next start.
REQ-023 busy=1 in every state except IDLE; start during busy is dropped, not latched.
REQ-024 upd_valid during busy stalls (upd_ready=0); the requester holds data until IDLE.
REQ-025 relax_reset and cycle_reset are never asserted together, and never asserted outside their RST states.

Reset
REQ-026 reset_n=0 at a clock edge: state=IDLE, pass_cnt=0, start_pend=0, adj_we=0, relax_reset=0, cycle_reset=0, done=0, busy=0, upd_ready=0 during reset, adj_wrow/wcol/wdata=0.
REQ-027 Reset mid-solve aborts without issuing done; a pending adjmat write is discarded.

Configuration
REQ-028 Macro SCHED_EARLY_EXIT_EN: when defined, relax_done=1 with relax_changed=0 in RELAX_RUN goes straight to CYC_RST after incrementing pass_cnt; when undefined, relax_changed is ignored and exactly NODES-1 passes always run.

Verification
REQ-029 NODES=4, start pulse, relax_done 5 cycles after each relax_reset -> 3 relax_reset pulses, 1 cycle_reset pulse, done once, pass_cnt=3.
REQ-030 IDLE, upd_valid with row=2, col=3, weight=-7 -> adj_we=1 next cycle with adj_wrow=2, adj_wcol=3, adj_wdata=-7, for one cycle only.
REQ-031 start and upd_valid in the same cycle -> write issued, relax_reset asserted 2 cycles after the start cycle.
REQ-032 upd_valid held during RELAX_RUN -> upd_ready=0 and no adj_we until FINISH->IDLE, then write issued once.
REQ-033 SCHED_EARLY_EXIT_EN defined, NODES=4, relax_changed=0 on pass 1 -> cycle_reset after one pass, pass_cnt=1; undefined -> 3 passes.
REQ-034 reset_n=0 during CYC_RUN -> all outputs at reset values next cycle, no done; new start then runs a full solve.

Source files
------------

// File: rtl/bf_scheduler.sv
// Bellman-Ford solve sequencer: gates adjacency-matrix updates, runs NODES-1 relaxation passes, then cycle detection.
// Optional macro SCHED_EARLY_EXIT_EN: stop relaxing as soon as a pass reports no change.
module bf_scheduler #(
   parameter int NODES = 32,
   parameter int PW    = 5,
   parameter int WW    = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          upd_valid,
   output logic          upd_ready,
   input  logic [PW-1:0] upd_row,
   input  logic [PW-1:0] upd_col,
   input  logic [WW-1:0] upd_weight,
   output logic          adj_we,
   output logic [PW-1:0] adj_wrow,
   output logic [PW-1:0] adj_wcol,
   output logic [WW-1:0] adj_wdata,
   output logic          relax_reset,
   input  logic          relax_done,
   input  logic          relax_changed,
   output logic          cycle_reset,
   input  logic          cycle_done,
   output logic          busy,
   output logic [PW-1:0] pass_cnt,
   output logic          done
);

   typedef enum logic [5:0] {
      IDLE      = 6'b000001,
      RELAX_RST = 6'b000010,
      RELAX_RUN = 6'b000100,
      CYC_RST   = 6'b001000,
      CYC_RUN   = 6'b010000,
      FINISH    = 6'b100000
   } state_t;

   localparam logic [PW-1:0] LAST = PW'(NODES - 1);

   state_t        state;
   logic          start_pend;
   logic          settle;     // first cycle after an engine reset: its done is stale
   logic [PW-1:0] pass_nxt;
   logic          last_pass;

   assign pass_nxt = pass_cnt + PW'(1);

`ifdef SCHED_EARLY_EXIT_EN
   assign last_pass = (pass_nxt == LAST) || !relax_changed;
`else
   logic unused_changed;
   assign unused_changed = relax_changed;
   assign last_pass      = (pass_nxt == LAST);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         pass_cnt    <= '0;
         start_pend  <= 1'b0;
         settle      <= 1'b0;
         adj_we      <= 1'b0;
         adj_wrow    <= '0;
         adj_wcol    <= '0;
         adj_wdata   <= '0;
         relax_reset <= 1'b0;
         cycle_reset <= 1'b0;
         done        <= 1'b0;
         busy        <= 1'b0;
         upd_ready   <= 1'b0;
      end else begin
         adj_we      <= 1'b0;
         relax_reset <= 1'b0;
         cycle_reset <= 1'b0;
         done        <= 1'b0;
         case (state)
            IDLE: begin
               upd_ready <= 1'b1;
               // an accepted update always wins the cycle; a coincident start waits one cycle
               if (upd_valid && upd_ready) begin
                  adj_we    <= 1'b1;
                  adj_wrow  <= upd_row;
                  adj_wcol  <= upd_col;
                  adj_wdata <= upd_weight;
                  if (start) start_pend <= 1'b1;
               end else if (start || start_pend) begin
                  state       <= RELAX_RST;
                  relax_reset <= 1'b1;
                  pass_cnt    <= '0;
                  start_pend  <= 1'b0;
                  busy        <= 1'b1;
                  upd_ready   <= 1'b0;
               end
            end
            RELAX_RST: begin
               state  <= RELAX_RUN;
               settle <= 1'b1;
            end
            RELAX_RUN: begin
               if (settle) begin
                  settle <= 1'b0;
               end else if (relax_done) begin
                  pass_cnt <= pass_nxt;
                  if (last_pass) begin
                     state       <= CYC_RST;
                     cycle_reset <= 1'b1;
                  end else begin
                     state       <= RELAX_RST;
                     relax_reset <= 1'b1;
                  end
               end
            end
            CYC_RST: begin
               state  <= CYC_RUN;
               settle <= 1'b1;
            end
            CYC_RUN: begin
               if (settle) begin
                  settle <= 1'b0;
               end else if (cycle_done) begin
                  state <= FINISH;
                  done  <= 1'b1;
               end
            end
            FINISH: begin
               state     <= IDLE;
               busy      <= 1'b0;
               upd_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               settle    <= 1'b0;
               busy      <= 1'b0;
               upd_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bf_scheduler.sv
// Randomized bench for bf_scheduler: emulated relax/cycle engines, write scoreboard and pass-count model.
module tb_bf_scheduler;
   localparam int NODES = 4;
   localparam int PW    = 5;
   localparam int WW    = 32;

   logic          clk = 1'b0;
   logic          reset_n, start, upd_valid, upd_ready;
   logic [PW-1:0] upd_row, upd_col, adj_wrow, adj_wcol, pass_cnt;
   logic [WW-1:0] upd_weight, adj_wdata;
   logic          adj_we, relax_reset, relax_done, relax_changed;
   logic          cycle_reset, cycle_done, busy, done;

   always #5 clk = ~clk;

   bf_scheduler #(.NODES(NODES), .PW(PW), .WW(WW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_row(upd_row), .upd_col(upd_col), .upd_weight(upd_weight),
      .adj_we(adj_we), .adj_wrow(adj_wrow), .adj_wcol(adj_wcol), .adj_wdata(adj_wdata),
      .relax_reset(relax_reset), .relax_done(relax_done), .relax_changed(relax_changed),
      .cycle_reset(cycle_reset), .cycle_done(cycle_done),
      .busy(busy), .pass_cnt(pass_cnt), .done(done)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // engine emulation and monitoring state
   int cyc = 0;
   int r_cnt = 0, r_clr = 0, c_cnt = 0, c_clr = 0;
   int dly_fix = 5;
   bit chg_rand = 0, first_zero = 0;
   bit chg_q[$];
   int n_rr, n_cr, n_done, n_wr, v_viol, t_rr_first, pc_first, pc_done;
   bit prev_rr, prev_cr, prev_dn, in_solve;

   function automatic int dly();
      return (dly_fix != 0) ? dly_fix : int'($urandom_range(8, 3));
   endfunction

   function automatic bit pick_chg();
      if (first_zero && chg_q.size() == 0) return 1'b0;
      if (chg_rand) return 1'($urandom_range(1, 0));
      return 1'b1;
   endfunction

   // NODES-1 passes, cut short by an unchanged pass only when early exit is built in
   function automatic int exp_passes();
      int p = 0;
      for (int i = 0; i < NODES - 1; i++) begin
         p++;
`ifdef SCHED_EARLY_EXIT_EN
         if (i < chg_q.size() && !chg_q[i]) break;
`endif
      end
      return p;
   endfunction

   task automatic clear_run();
      n_rr = 0; n_cr = 0; n_done = 0; n_wr = 0; v_viol = 0;
      t_rr_first = -1; pc_first = -1; pc_done = -1; in_solve = 0;
      chg_q.delete();
   endtask

   task automatic step();
      bit acc;
      logic [PW-1:0] er, ec;
      logic [WW-1:0] ew;
      acc = reset_n && upd_valid && upd_ready;
      er = upd_row; ec = upd_col; ew = upd_weight;
      @(posedge clk); #1;
      cyc++;
      if (acc) upd_valid = 1'b0;
      if (acc || adj_we) begin
         chk("adj_we", adj_we, acc);
         if (acc) begin
            chk("adj_wrow", adj_wrow, er);
            chk("adj_wcol", adj_wcol, ec);
            chk("adj_wdata", adj_wdata, ew);
         end
         if (adj_we) n_wr++;
      end
      if (relax_reset && cycle_reset) v_viol++;
      if ((relax_reset || cycle_reset) && !busy) v_viol++;
      if ((relax_reset && prev_rr) || (cycle_reset && prev_cr) || (done && prev_dn)) v_viol++;
      if (upd_ready && busy) v_viol++;
      if (in_solve && !busy) v_viol++;
      if (relax_reset) begin
         n_rr++;
         in_solve = 1;
         if (t_rr_first < 0) begin t_rr_first = cyc; pc_first = int'(pass_cnt); end
      end
      if (cycle_reset) n_cr++;
      if (done) begin n_done++; pc_done = int'(pass_cnt); in_solve = 0; end
      prev_rr = relax_reset; prev_cr = cycle_reset; prev_dn = done;
      // engines keep done high for two cycles after their reset (stale), then respond later
      if (relax_reset) begin
         r_cnt = dly(); r_clr = 2;
      end else begin
         if (r_clr > 0) begin r_clr--; if (r_clr == 0) relax_done = 1'b0; end
         if (r_cnt > 0) begin
            r_cnt--;
            if (r_cnt == 0) begin
               relax_done = 1'b1;
               relax_changed = pick_chg();
               chg_q.push_back(relax_changed);
            end
         end
      end
      if (cycle_reset) begin
         c_cnt = dly(); c_clr = 2;
      end else begin
         if (c_clr > 0) begin c_clr--; if (c_clr == 0) cycle_done = 1'b0; end
         if (c_cnt > 0) begin c_cnt--; if (c_cnt == 0) cycle_done = 1'b1; end
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20 && !upd_ready; i++) step();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rdy"}, upd_ready, 0);
      chk({tag, "_we"}, adj_we, 0);
      chk({tag, "_rrst"}, relax_reset, 0);
      chk({tag, "_crst"}, cycle_reset, 0);
      chk({tag, "_pass"}, pass_cnt, 0);
      chk({tag, "_wbus"}, {adj_wrow, adj_wcol, adj_wdata}, 0);
   endtask

   task automatic run_solve(input bit with_upd, input bit mid_upd, input bit rnd_start);
      int t0, ep;
      wait_ready();
      clear_run();
      if (with_upd) begin
         upd_row = PW'($urandom); upd_col = PW'($urandom); upd_weight = $urandom;
         upd_valid = 1'b1;
      end
      t0 = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3000 && n_done == 0; i++) begin
         if (mid_upd && i == 6) begin
            upd_row = PW'($urandom); upd_col = PW'($urandom); upd_weight = $urandom;
            upd_valid = 1'b1;
         end
         if (rnd_start) start = ($urandom_range(7, 0) == 0);
         step();
      end
      start = 1'b0;
      ep = exp_passes();
      chk("pass_at_done", pc_done, ep);
      repeat (4) step();
      chk("done_cnt", n_done, 1);
      chk("relax_rst_cnt", n_rr, ep);
      chk("cyc_rst_cnt", n_cr, 1);
      chk("pass_hold", pass_cnt, ep);
      chk("idle_after", busy, 0);
      chk("rr_latency", t_rr_first - t0, with_upd ? 2 : 1);
      chk("pass_clr", pc_first, 0);
      chk("wr_cnt", n_wr, int'(with_upd) + int'(mid_upd));
      chk("protocol", v_viol, 0);
   endtask

   task automatic mid_reset();
      wait_ready();
      clear_run();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3000 && n_cr == 0; i++) step();
      step(); step();
      chk("mrst_in_cyc", busy, 1);
      reset_n = 1'b0;
      step();
      check_reset("mrst");
      reset_n = 1'b1;
      repeat (3) step();
      chk("mrst_no_done", n_done, 0);
      chk("mrst_idle", busy, 0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; upd_valid = 1'b0;
      upd_row = '0; upd_col = '0; upd_weight = '0;
      relax_done = 1'b0; relax_changed = 1'b1; cycle_done = 1'b0;
      prev_rr = 0; prev_cr = 0; prev_dn = 0;
      clear_run();
      repeat (3) step();
      check_reset("por");
      reset_n = 1'b1;
      step();

      // single edge update, row 2 col 3 weight -7
      wait_ready();
      upd_row = 5'd2; upd_col = 5'd3; upd_weight = 32'hFFFF_FFF9;
      upd_valid = 1'b1;
      step();
      chk("upd_we", adj_we, 1);
      chk("upd_data", adj_wdata, 32'hFFFF_FFF9);
      step();
      chk("upd_one_cycle", adj_we, 0);

      dly_fix = 5; chg_rand = 0; first_zero = 0;
      run_solve(0, 0, 0);
      run_solve(1, 0, 0);
      run_solve(0, 1, 1);
      first_zero = 1;
      run_solve(0, 0, 0);
      first_zero = 0;
      mid_reset();
      run_solve(0, 0, 0);

      dly_fix = 0; chg_rand = 1;
      for (int k = 0; k < 12; k++) begin
         repeat ($urandom_range(3, 0)) begin
            wait_ready();
            upd_row = PW'($urandom); upd_col = PW'($urandom); upd_weight = $urandom;
            upd_valid = 1'b1;
            step();
         end
         for (int i = 0; i < 20 && upd_valid; i++) step();
         upd_valid = 1'b0;
         step();
         run_solve(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
